// File: rtl/plab5_mcore_mem_xbar.sv
// N-port memory crossbar: per-requester request queues, per-bank round-robin arbiters and
// in-order tag FIFOs for response routing. Define PLAB5_MCORE_MEM_XBAR_BYPASS_EN for empty-queue bypass.
module plab5_mcore_mem_xbar #(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_ports        = 4,
  parameter int p_queue_depth      = 2,
  parameter int p_max_outstanding  = 4,
  parameter bit p_single_bank      = 1'b0,
  parameter int p_bank_sel_lsb     = 4,
  localparam int LW = $clog2(p_mem_data_nbits/8),
  localparam int RQ = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LW + p_mem_data_nbits,
  localparam int RS = 3 + p_mem_opaque_nbits + 2 + LW + p_mem_data_nbits
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_num_ports-1:0][RQ-1:0] req_in_msg,
  input  logic [p_num_ports-1:0]     req_in_val,
  output logic [p_num_ports-1:0]     req_in_rdy,
  output logic [p_num_ports-1:0][RS-1:0] resp_out_msg,
  output logic [p_num_ports-1:0]     resp_out_val,
  input  logic [p_num_ports-1:0]     resp_out_rdy,
  output logic [p_num_ports-1:0][RQ-1:0] req_out_msg,
  output logic [p_num_ports-1:0]     req_out_val,
  input  logic [p_num_ports-1:0]     req_out_rdy,
  input  logic [p_num_ports-1:0][RS-1:0] resp_in_msg,
  input  logic [p_num_ports-1:0]     resp_in_val,
  output logic [p_num_ports-1:0]     resp_in_rdy
);
  localparam int N        = p_num_ports;
  localparam int IW       = $clog2(N);
  localparam int D        = p_queue_depth;
  localparam int M        = p_max_outstanding;
  localparam int QPW      = (D > 1) ? $clog2(D) : 1;
  localparam int QCW      = $clog2(D + 1);
  localparam int TPW      = (M > 1) ? $clog2(M) : 1;
  localparam int TCW      = $clog2(M + 1);
  localparam int ADDR_LSB = LW + p_mem_data_nbits;

  logic [N-1:0]          head_val;
  logic [N-1:0][RQ-1:0]  head_msg;
  logic [N-1:0][IW-1:0]  head_bank;
  logic [N-1:0]          deq;
  logic [N-1:0][IW-1:0]  rq_ptr, rq_win, rs_ptr, rs_win;
  logic [N-1:0]          rq_any, rs_any;
  logic [N-1:0]          tag_full, tag_empty;
  logic [N-1:0][IW-1:0]  tag_head;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] w);
    return (w == IW'(N-1)) ? '0 : w + 1'b1;
  endfunction

  // Per-requester request queues
  for (genvar i = 0; i < N; i++) begin : g_q
    logic [RQ-1:0]  mem [D];
    logic [QPW-1:0] rd, wr;
    logic [QCW-1:0] cnt;
    logic           empty, full, enq, pop;

    assign empty         = (cnt == '0);
    assign full          = (cnt == QCW'(D));
    assign req_in_rdy[i] = reset & ~full;
    // A head consumed while the queue is empty was the bypassed input, so it is not stored
    assign enq           = req_in_val[i] & req_in_rdy[i] & ~(empty & deq[i]);
    assign pop           = deq[i] & ~empty;
`ifdef PLAB5_MCORE_MEM_XBAR_BYPASS_EN
    assign head_val[i]   = ~empty | (reset & req_in_val[i]);
    assign head_msg[i]   = empty ? req_in_msg[i] : mem[rd];
`else
    assign head_val[i]   = ~empty;
    assign head_msg[i]   = mem[rd];
`endif
    assign head_bank[i]  = p_single_bank ? '0 : head_msg[i][ADDR_LSB + p_bank_sel_lsb +: IW];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd  <= '0;
        wr  <= '0;
        cnt <= '0;
      end else begin
        if (enq) wr <= (wr == QPW'(D-1)) ? '0 : wr + 1'b1;
        if (pop) rd <= (rd == QPW'(D-1)) ? '0 : rd + 1'b1;
        if (enq && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !enq) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk)
      if (enq) mem[wr] <= req_in_msg[i];
  end

  // Per-bank tag FIFOs: source port of each in-flight request, oldest at head
  for (genvar b = 0; b < N; b++) begin : g_tag
    logic [IW-1:0]  mem [M];
    logic [TPW-1:0] rd, wr;
    logic [TCW-1:0] cnt;
    logic           push, pop;

    assign push         = req_out_val[b] & req_out_rdy[b];
    assign pop          = resp_in_val[b] & resp_in_rdy[b];
    assign tag_empty[b] = (cnt == '0);
    assign tag_full[b]  = (cnt == TCW'(M));
    assign tag_head[b]  = mem[rd];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd  <= '0;
        wr  <= '0;
        cnt <= '0;
      end else begin
        if (push) wr <= (wr == TPW'(M-1)) ? '0 : wr + 1'b1;
        if (pop)  rd <= (rd == TPW'(M-1)) ? '0 : rd + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk)
      if (push) mem[wr] <= rq_win[b];

    always_ff @(posedge clk)
      if (reset && resp_in_val[b] && tag_empty[b])
        $error("plab5_mcore_mem_xbar: response on bank %0d with no outstanding request", b);
  end

  // Request arbitration: first queue head at or after the bank's pointer
  always_comb begin
    int idx;
    idx    = 0;
    rq_any = '0;
    rq_win = '0;
    for (int b = 0; b < N; b++) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rq_ptr[b]) + k;
        if (idx >= N) idx = idx - N;
        if (!rq_any[b] && head_val[idx] && head_bank[idx] == IW'(b)) begin
          rq_any[b] = 1'b1;
          rq_win[b] = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_out_val = '0;
    req_out_msg = '0;
    deq         = '0;
    for (int b = 0; b < N; b++) begin
      req_out_val[b] = reset & rq_any[b] & ~tag_full[b] & (!p_single_bank || b == 0);
      req_out_msg[b] = head_msg[rq_win[b]];
      if (req_out_val[b] && req_out_rdy[b]) deq[rq_win[b]] = 1'b1;
    end
  end

  // Response arbitration: banks whose oldest tag names this port compete round-robin
  always_comb begin
    int idx;
    idx    = 0;
    rs_any = '0;
    rs_win = '0;
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rs_ptr[p]) + k;
        if (idx >= N) idx = idx - N;
        if (!rs_any[p] && resp_in_val[idx] && !tag_empty[idx] && tag_head[idx] == IW'(p)) begin
          rs_any[p] = 1'b1;
          rs_win[p] = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    resp_out_val = '0;
    resp_out_msg = '0;
    resp_in_rdy  = '0;
    for (int p = 0; p < N; p++) begin
      resp_out_val[p] = reset & rs_any[p];
      resp_out_msg[p] = resp_in_msg[rs_win[p]];
      if (resp_out_val[p] && resp_out_rdy[p]) resp_in_rdy[rs_win[p]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_ptr <= '0;
      rs_ptr <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (req_out_val[k] && req_out_rdy[k])   rq_ptr[k] <= nxt(rq_win[k]);
        if (resp_out_val[k] && resp_out_rdy[k]) rs_ptr[k] <= nxt(rs_win[k]);
      end
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_xbar.sv
// Directed bench for plab5_mcore_mem_xbar at default parameters (4 ports, queue 2, 4 outstanding).
module tb_plab5_mcore_mem_xbar;
  logic clk = 1'b0;
  logic reset;
  logic [3:0][76:0] req_in_msg, req_out_msg;
  logic [3:0]       req_in_val, req_in_rdy, req_out_val, req_out_rdy;
  logic [3:0][46:0] resp_in_msg, resp_out_msg;
  logic [3:0]       resp_in_val, resp_in_rdy, resp_out_val, resp_out_rdy;

  int tests = 0;
  int fails = 0;

  plab5_mcore_mem_xbar dut (
    .clk(clk), .reset(reset),
    .req_in_msg(req_in_msg), .req_in_val(req_in_val), .req_in_rdy(req_in_rdy),
    .resp_out_msg(resp_out_msg), .resp_out_val(resp_out_val), .resp_out_rdy(resp_out_rdy),
    .req_out_msg(req_out_msg), .req_out_val(req_out_val), .req_out_rdy(req_out_rdy),
    .resp_in_msg(resp_in_msg), .resp_in_val(resp_in_val), .resp_in_rdy(resp_in_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [76:0] mk_req(input logic [7:0] opq, input logic [31:0] addr,
                                         input logic [31:0] data);
    return {3'd0, opq, addr, 2'd0, data};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [7:0] opq, input logic [31:0] data);
    return {3'd0, opq, 2'd0, 2'd0, data};
  endfunction

  task automatic do_reset();
    reset        = 1'b0;
    req_in_val   = '0;
    resp_in_val  = '0;
    req_in_msg   = '0;
    resp_in_msg  = '0;
    req_out_rdy  = '0;
    resp_out_rdy = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    req_in_val   = 4'hF;
    resp_in_val  = '0;
    req_in_msg   = '0;
    resp_in_msg  = '0;
    req_out_rdy  = 4'hF;
    resp_out_rdy = 4'hF;
    @(negedge clk); #1;
    tests++; if (req_in_rdy !== 4'h0) begin fails++; $display("FAIL reset_req_in_rdy got %b exp 0000", req_in_rdy); end
    tests++; if (req_out_val !== 4'h0) begin fails++; $display("FAIL reset_req_out_val got %b exp 0000", req_out_val); end
    tests++; if (resp_out_val !== 4'h0) begin fails++; $display("FAIL reset_resp_out_val got %b exp 0000", resp_out_val); end
    tests++; if (resp_in_rdy !== 4'h0) begin fails++; $display("FAIL reset_resp_in_rdy got %b exp 0000", resp_in_rdy); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [76:0] rq;
    logic [46:0] rs;
    rq = mk_req(8'h11, 32'h20, 32'hCAFE0001);
    rs = mk_resp(8'h11, 32'h5A5A0001);
    @(negedge clk);
    req_out_rdy   = 4'hF;
    resp_out_rdy  = 4'hF;
    req_in_msg[0] = rq;
    req_in_val[0] = 1'b1;
    #1;
    tests++; if (req_in_rdy[0] !== 1'b1) begin fails++; $display("FAIL basic_in_rdy got %b exp 1", req_in_rdy[0]); end
`ifdef PLAB5_MCORE_MEM_XBAR_BYPASS_EN
    tests++; if (req_out_val !== 4'b0100 || req_out_msg[2] !== rq) begin fails++; $display("FAIL basic_bypass got val %b msg %h exp 0100 %h", req_out_val, req_out_msg[2], rq); end
    @(negedge clk);
    req_in_val[0] = 1'b0;
`else
    tests++; if (req_out_val !== 4'b0000) begin fails++; $display("FAIL basic_latency got %b exp 0000", req_out_val); end
    @(negedge clk);
    req_in_val[0] = 1'b0;
    #1;
    tests++; if (req_out_val !== 4'b0100 || req_out_msg[2] !== rq) begin fails++; $display("FAIL basic_req_out got val %b msg %h exp 0100 %h", req_out_val, req_out_msg[2], rq); end
`endif
    @(negedge clk);
    tests++; if (req_out_val !== 4'b0000) begin fails++; $display("FAIL basic_req_done got %b exp 0000", req_out_val); end
    resp_in_msg[2] = rs;
    resp_in_val[2] = 1'b1;
    #1;
    tests++; if (resp_out_val !== 4'b0001 || resp_out_msg[0] !== rs) begin fails++; $display("FAIL basic_resp got val %b msg %h exp 0001 %h", resp_out_val, resp_out_msg[0], rs); end
    tests++; if (resp_in_rdy !== 4'b0100) begin fails++; $display("FAIL basic_resp_rdy got %b exp 0100", resp_in_rdy); end
    @(negedge clk);
    resp_in_val[2] = 1'b0;
    #1;
    tests++; if (resp_out_val !== 4'b0000) begin fails++; $display("FAIL basic_resp_done got %b exp 0000", resp_out_val); end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rs;
    @(negedge clk);
    req_out_rdy  = 4'hF;
    resp_out_rdy = 4'hF;
    for (int i = 0; i < 4; i++) req_in_msg[i] = mk_req(8'(i), 32'h0, 32'(i));
    req_in_val = 4'hF;
`ifndef PLAB5_MCORE_MEM_XBAR_BYPASS_EN
    @(negedge clk);
`endif
    for (int k = 0; k < 8; k++) begin
      resp_in_val[0] = (k > 0);
      resp_in_msg[0] = mk_resp(8'(k), 32'(k));
      #1;
      tests++; if (req_out_val !== 4'b0001 || req_out_msg[0] !== mk_req(8'(k % 4), 32'h0, 32'(k % 4)))
        begin fails++; $display("FAIL rr_grant%0d got val %b msg %h exp port %0d", k, req_out_val, req_out_msg[0], k % 4); end
      if (k > 0) begin
        exp_rs = 4'(1 << ((k - 1) % 4));
        tests++; if (resp_out_val !== exp_rs) begin fails++; $display("FAIL rr_resp%0d got %b exp %b", k, resp_out_val, exp_rs); end
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_max_outstanding();
    int nxf;
    @(negedge clk);
    req_out_rdy   = 4'hF;
    resp_out_rdy  = 4'hF;
    req_in_msg[0] = mk_req(8'h05, 32'h10, 32'h1);
    req_in_val[0] = 1'b1;
    nxf = 0;
`ifdef PLAB5_MCORE_MEM_XBAR_BYPASS_EN
    #1;
    tests++; if (req_out_val !== 4'b0010) begin fails++; $display("FAIL maxout_xfer0 got %b exp 0010", req_out_val); end
    nxf = 1;
`endif
    while (nxf < 4) begin
      @(negedge clk); #1;
      tests++; if (req_out_val !== 4'b0010) begin fails++; $display("FAIL maxout_xfer%0d got %b exp 0010", nxf, req_out_val); end
      nxf++;
    end
    @(negedge clk); #1;
    tests++; if (req_out_val !== 4'b0000) begin fails++; $display("FAIL maxout_full got %b exp 0000", req_out_val); end
    resp_in_msg[1] = mk_resp(8'h05, 32'h99);
    resp_in_val[1] = 1'b1;
    #1;
    tests++; if (resp_in_rdy !== 4'b0010 || resp_out_val !== 4'b0001) begin fails++; $display("FAIL maxout_resp got rdy %b val %b exp 0010 0001", resp_in_rdy, resp_out_val); end
    tests++; if (req_out_val !== 4'b0000) begin fails++; $display("FAIL maxout_push_blocked got %b exp 0000", req_out_val); end
    @(negedge clk);
    resp_in_val[1] = 1'b0;
    #1;
    tests++; if (req_out_val !== 4'b0010) begin fails++; $display("FAIL maxout_restore got %b exp 0010", req_out_val); end
    @(negedge clk); #1;
    tests++; if (req_out_val !== 4'b0000) begin fails++; $display("FAIL maxout_refull got %b exp 0000", req_out_val); end
    do_reset();
  endtask

  task automatic test_back_pressure();
    logic [76:0] a, b, c;
    a = mk_req(8'hA0, 32'h30, 32'hA);
    b = mk_req(8'hB0, 32'h30, 32'hB);
    c = mk_req(8'hC0, 32'h30, 32'hC);
    @(negedge clk);
    resp_out_rdy  = 4'hF;
    req_in_msg[3] = a;
    req_in_val[3] = 1'b1;
    #1;
    tests++; if (req_in_rdy[3] !== 1'b1) begin fails++; $display("FAIL bp_rdy_a got %b exp 1", req_in_rdy[3]); end
    @(negedge clk);
    req_in_msg[3] = b;
    #1;
    tests++; if (req_in_rdy[3] !== 1'b1) begin fails++; $display("FAIL bp_rdy_b got %b exp 1", req_in_rdy[3]); end
    @(negedge clk);
    req_in_msg[3] = c;
    #1;
    tests++; if (req_in_rdy[3] !== 1'b0) begin fails++; $display("FAIL bp_full got %b exp 0", req_in_rdy[3]); end
    @(negedge clk); #1;
    tests++; if (req_in_rdy[3] !== 1'b0) begin fails++; $display("FAIL bp_full_hold got %b exp 0", req_in_rdy[3]); end
    tests++; if (req_out_val !== 4'b1000 || req_out_msg[3] !== a) begin fails++; $display("FAIL bp_head_a got val %b msg %h exp 1000 %h", req_out_val, req_out_msg[3], a); end
    req_out_rdy = 4'hF;
    @(negedge clk); #1;
    tests++; if (req_in_rdy[3] !== 1'b1 || req_out_msg[3] !== b) begin fails++; $display("FAIL bp_head_b got rdy %b msg %h exp 1 %h", req_in_rdy[3], req_out_msg[3], b); end
    @(negedge clk);
    req_in_val[3] = 1'b0;
    #1;
    tests++; if (req_out_val !== 4'b1000 || req_out_msg[3] !== c) begin fails++; $display("FAIL bp_head_c got val %b msg %h exp 1000 %h", req_out_val, req_out_msg[3], c); end
    @(negedge clk); #1;
    tests++; if (req_out_val !== 4'b0000) begin fails++; $display("FAIL bp_drained got %b exp 0000", req_out_val); end
    do_reset();
  endtask

  task automatic test_resp_arb();
    logic [3:0] exp_rdy;
    logic [46:0] exp_msg;
    int          bank;
    @(negedge clk);
    req_out_rdy  = 4'hF;
    resp_out_rdy = 4'hF;
    for (int j = 0; j < 4; j++) begin
      req_in_msg[1] = mk_req(8'(j), (j % 2 == 0) ? 32'h00 : 32'h20, 32'(j));
      req_in_val[1] = 1'b1;
      #1;
      tests++; if (req_in_rdy[1] !== 1'b1) begin fails++; $display("FAIL arb_in_rdy%0d got %b exp 1", j, req_in_rdy[1]); end
      @(negedge clk);
    end
    req_in_val[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      resp_in_val    = (c == 3) ? 4'b0100 : 4'b0101;
      resp_in_msg[0] = mk_resp(8'h00, 32'(c));
      resp_in_msg[2] = mk_resp(8'h02, 32'(c));
      bank    = (c % 2 == 0) ? 0 : 2;
      exp_rdy = 4'(1 << bank);
      exp_msg = mk_resp(8'(bank), 32'(c));
      #1;
      tests++; if (resp_out_val !== 4'b0010 || resp_out_msg[1] !== exp_msg) begin fails++; $display("FAIL arb_resp%0d got val %b msg %h exp 0010 %h", c, resp_out_val, resp_out_msg[1], exp_msg); end
      tests++; if (resp_in_rdy !== exp_rdy) begin fails++; $display("FAIL arb_rdy%0d got %b exp %b", c, resp_in_rdy, exp_rdy); end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_reset_inflight();
    logic [76:0] rq;
    logic [46:0] rs;
    rq = mk_req(8'h77, 32'h10, 32'h12345678);
    rs = mk_resp(8'h77, 32'h87654321);
    @(negedge clk);
    resp_out_rdy  = 4'hF;
    req_in_msg[0] = mk_req(8'h01, 32'h10, 32'h1);
    req_in_val[0] = 1'b1;
    @(negedge clk);
    req_in_msg[0] = mk_req(8'h02, 32'h10, 32'h2);
    @(negedge clk);
    req_in_val[0] = 1'b0;
    #1;
    tests++; if (req_out_val !== 4'b0010 || req_in_rdy[0] !== 1'b0) begin fails++; $display("FAIL rst_pre got val %b rdy %b exp 0010 0", req_out_val, req_in_rdy[0]); end
    #2;
    reset       = 1'b0;
    req_out_rdy = 4'hF;
    #1;
    tests++; if (req_out_val !== 4'h0 || req_in_rdy !== 4'h0) begin fails++; $display("FAIL rst_async got val %b rdy %b exp 0000 0000", req_out_val, req_in_rdy); end
    tests++; if (resp_out_val !== 4'h0 || resp_in_rdy !== 4'h0) begin fails++; $display("FAIL rst_async_resp got val %b rdy %b exp 0000 0000", resp_out_val, resp_in_rdy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (req_out_val !== 4'h0) begin fails++; $display("FAIL rst_discard got %b exp 0000", req_out_val); end
    req_in_msg[0] = rq;
    req_in_val[0] = 1'b1;
`ifdef PLAB5_MCORE_MEM_XBAR_BYPASS_EN
    #1;
    tests++; if (req_out_val !== 4'b0010 || req_out_msg[1] !== rq) begin fails++; $display("FAIL rst_post_req got val %b msg %h exp 0010 %h", req_out_val, req_out_msg[1], rq); end
    @(negedge clk);
    req_in_val[0] = 1'b0;
`else
    @(negedge clk);
    req_in_val[0] = 1'b0;
    #1;
    tests++; if (req_out_val !== 4'b0010 || req_out_msg[1] !== rq) begin fails++; $display("FAIL rst_post_req got val %b msg %h exp 0010 %h", req_out_val, req_out_msg[1], rq); end
`endif
    @(negedge clk);
    resp_in_msg[1] = rs;
    resp_in_val[1] = 1'b1;
    #1;
    tests++; if (resp_out_val !== 4'b0001 || resp_out_msg[0] !== rs || resp_in_rdy !== 4'b0010) begin fails++; $display("FAIL rst_post_resp got val %b msg %h rdy %b exp 0001 %h 0010", resp_out_val, resp_out_msg[0], resp_in_rdy, rs); end
    @(negedge clk);
    resp_in_val[1] = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_max_outstanding();
    test_back_pressure();
    test_resp_arb();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_xbar.md
PLAB5_MCORE_MEM_XBAR -- requirements
Module: plab5_mcore_mem_xbar

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  p_mem_opaque_nbits 8, mem msg opaque width; p_mem_addr_nbits 32, address width; p_mem_data_nbits 32, data width
  p_num_ports 4, requester ports = bank ports, 2..16
  p_queue_depth 2, per-input request queue entries, >=1
  p_max_outstanding 4, per-bank in-flight request limit, >=1
  p_single_bank 0, 1 = all requests routed to bank 0
  p_bank_sel_lsb 4, lowest address bit of bank index
REQ-002 Ports (name direction width meaning); N = p_num_ports, rq/rs = VC mem req/resp msg widths:
  clk  input  1  clock, rising edge
  reset  input  1  reset, asynchronous, active-low
  req_in_msg/val/rdy  in/in/out  rq*N / N / N  requester-side requests
  resp_out_msg/val/rdy  out/out/in  rs*N / N / N  requester-side responses
  req_out_msg/val/rdy  out/out/in  rq*N / N / N  bank-side requests
  resp_in_msg/val/rdy  in/in/out  rs*N / N / N  bank-side responses
REQ-003 One clock, clk; reset is asynchronous and active-low; all state in the clk domain.

Function
REQ-004 Transfer on any channel occurs only in a cycle where val and rdy are both 1; messages pass bit-exact, no field rewritten.
REQ-005 Each input port has a FIFO of p_queue_depth entries; req_in_rdy[i] = queue not full, with no combinational dependence on req_in_val.
REQ-006 A full queue refuses enqueue even when dequeuing in the same cycle.
REQ-007 Destination bank = addr[p_bank_sel_lsb +: clog2(N)]; p_single_bank=1 forces bank 0.
REQ-008 Without bypass, a request enqueued at cycle t is first presentable on req_out at cycle t+1.
REQ-009 Each bank has a round-robin arbiter over queue heads addressed to it; the priority pointer moves to winner+1 (mod N) only on a req_out transfer, otherwise holds.
REQ-010 Each bank has a tag FIFO of p_max_outstanding entries holding source port ids; a req_out transfer pushes the winner id.
REQ-011 req_out_val[b] is 0 while bank b's tag FIFO is full; push is blocked when full even if a pop occurs that cycle.
REQ-012 Banks respond in request order; the response at resp_in[b] routes to port = head of tag FIFO b; a resp_in transfer pops it.
REQ-013 Each output port has a round-robin arbiter over banks whose tag head names that port; pointer advances on resp_out transfer only.
REQ-014 resp_in_rdy[b] = granted & resp_out_rdy[dest]; response path is combinational, zero cycles.
REQ-015 resp_in_val[b] with empty tag FIFO: resp_in_rdy[b]=0, simulation error message printed.
REQ-016 p_single_bank=1: req_out_val[1..N-1]=0, resp_in_rdy[1..N-1]=0 permanently.
REQ-017 Per (source, bank) pair, request order and response order are preserved.

Reset
REQ-018 reset low: all queues and tag FIFOs empty, all arbiter pointers 0, immediately and regardless of clk.
REQ-019 During reset: req_out_val, resp_out_val, req_in_rdy, resp_in_rdy all 0; in-flight requests are discarded.
REQ-020 First transfer accepted on the first rising edge after reset deasserts.

Configuration
REQ-021 Macro PLAB5_MCORE_MEM_XBAR_BYPASS_EN defined: a request arriving at an empty queue is presented on req_out in the same cycle and not enqueued if it transfers; req_in_rdy stays = not full.
REQ-022 Macro undefined: no bypass; REQ-008 latency applies; behaviour otherwise identical.

Verification
REQ-023 N=4, port 0 read addr 0x20 (bank 2), all rdy=1 -> req_out_val[2]=1 at t+1 (t with bypass); response returns on resp_out port 0, bank 2 tag FIFO empty after.
REQ-024 Ports 0-3 each issue continuously to addr 0x00 -> bank 0 grants 0,1,2,3,0,... with no starvation.
REQ-025 p_max_outstanding=4, bank 1 resp_in_val held 0 -> after 4 transfers req_out_val[1]=0; one response restores val next cycle.
REQ-026 req_out_rdy=0, port 3 sends 3 requests with p_queue_depth=2 -> req_in_rdy[3]=0 after second; third held by source, delivered after rdy.
REQ-027 Banks 0 and 2 respond to port 1 simultaneously -> one per cycle, round-robin, resp_in_rdy of loser 0.
REQ-028 Reset asserted with 2 outstanding -> all val/rdy 0 immediately; post-reset request to addr 0x10 completes normally.
